scr1_tcm_portb_arb: RTL and testbench

Two-requester arbiter and access sequencer for port B of the TCM dual-port memory. It shares port B between the core data path (M0) and a debug/loader master (M1) using round-robin arbitration. It converts byte/half/word accesses into word-addressed byte-enabled memory cycles and returns aligned read data with a registered one-cycle response. Port A (instruction fetch) is outside this block.

---
 rtl/scr1_tcm_portb_arb_if.sv | 24 ++
 rtl/scr1_tcm_portb_arb.sv | 240 ++++++++++++++++++++++++
 tb/tb_scr1_tcm_portb_arb.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scr1_tcm_portb_arb_if.sv
// Requester-side bus for TCM port B: request/command/address/data toward the
// arbiter, and ack plus registered response back to the master.
interface scr1_tcm_portb_arb_if #(
  parameter int unsigned AW = 32'd16
) ();
  logic          req;
  logic          cmd;
  logic [1:0]    width;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          req_ack;
  logic [31:0]   rdata;
  logic [1:0]    resp;

  modport master (
    output req, cmd, width, addr, wdata,
    input  req_ack, rdata, resp
  );

  modport slave (
    input  req, cmd, width, addr, wdata,
    output req_ack, rdata, resp
  );
endinterface

// File: rtl/scr1_tcm_portb_arb.sv
// Round-robin arbiter for TCM port B shared by core data (M0) and debug/loader (M1).
// Builds byte-enabled word cycles and returns aligned read data one cycle after grant.
module scr1_tcm_portb_arb #(
  parameter int unsigned  SCR1_SIZE  = 32'h0001_0000,
  parameter int unsigned  SCR1_WIDTH = 32'd32,
  localparam int unsigned AW         = $clog2(SCR1_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  scr1_tcm_portb_arb_if.slave   m0,
  scr1_tcm_portb_arb_if.slave   m1,
  output logic                  mem_renb_o,
  output logic                  mem_wenb_o,
  output logic [3:0]            mem_webb_o,
  output logic [AW-3:0]         mem_addrb_o,
  output logic [SCR1_WIDTH-1:0] mem_datab_o,
  input  logic [SCR1_WIDTH-1:0] mem_qb_i
);

  localparam logic [1:0] W_BYTE   = 2'b00;
  localparam logic [1:0] W_HALF   = 2'b01;
  localparam logic [1:0] W_WORD   = 2'b10;
  localparam logic [1:0] RESP_IDLE = 2'b00;
  localparam logic [1:0] RESP_OK   = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b10;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  function automatic logic misaligned_f(input logic [1:0] width, input logic [1:0] off);
    logic bad;
    case (width)
      W_BYTE:  bad = 1'b0;
      W_HALF:  bad = off[0];
      W_WORD:  bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] webb_f(input logic [1:0] width, input logic [1:0] off);
    logic [3:0] be;
    case (width)
      W_BYTE:  be = 4'b0001 << off;
      W_HALF:  be = 4'b0011 << off;
      W_WORD:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] datab_f(input logic [1:0] width, input logic [31:0] wdata);
    logic [31:0] d;
    case (width)
      W_BYTE:  d = {4{wdata[7:0]}};
      W_HALF:  d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] rdata_align_f(input logic [1:0] width, input logic [1:0] off,
                                                input logic [31:0] qb);
    logic [31:0] sh;
    logic [31:0] r;
    sh = qb >> {off, 3'b000};
    case (width)
      W_BYTE:  r = {24'h00_0000, sh[7:0]};
      W_HALF:  r = {16'h0000, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  owner_e        last_grant_q, last_grant_d;
  logic          rsp_vld_q, rsp_vld_d;
  owner_e        rsp_owner_q, rsp_owner_d;
  logic          rsp_err_q, rsp_err_d;
  logic          rsp_cmd_q, rsp_cmd_d;
  logic [1:0]    rsp_width_q, rsp_width_d;
  logic [1:0]    rsp_off_q, rsp_off_d;
  logic [1:0]    m0_resp_q, m0_resp_d;
  logic [1:0]    m1_resp_q, m1_resp_d;

  logic          gnt_m0_s;
  logic          gnt_m1_s;
  logic          gnt_any_s;
  logic          sel_cmd_s;
  logic [1:0]    sel_width_s;
  logic [AW-1:0] sel_addr_s;
  logic [31:0]   sel_wdata_s;
  logic          sel_err_s;
  logic [31:0]   rd_aligned_s;
  logic          rd_valid_s;

  // Round-robin grant; the master not served last wins a tie, nothing is granted in reset
  always_comb begin
    gnt_m0_s = 1'b0;
    gnt_m1_s = 1'b0;
    if (rst) begin
      gnt_m0_s = 1'b0;
      gnt_m1_s = 1'b0;
    end else if (m0.req && m1.req) begin
      if (last_grant_q == OWN_M1) begin
        gnt_m0_s = 1'b1;
      end else begin
        gnt_m1_s = 1'b1;
      end
    end else if (m0.req) begin
      gnt_m0_s = 1'b1;
    end else if (m1.req) begin
      gnt_m1_s = 1'b1;
    end else begin
      gnt_m0_s = 1'b0;
      gnt_m1_s = 1'b0;
    end
  end

  assign gnt_any_s  = gnt_m0_s | gnt_m1_s;
  assign m0.req_ack = gnt_m0_s;
  assign m1.req_ack = gnt_m1_s;

  // Request mux; M0 drives the memory address/data buses whenever M1 is not granted
  always_comb begin
    sel_cmd_s   = m0.cmd;
    sel_width_s = m0.width;
    sel_addr_s  = m0.addr;
    sel_wdata_s = m0.wdata;
    if (gnt_m1_s) begin
      sel_cmd_s   = m1.cmd;
      sel_width_s = m1.width;
      sel_addr_s  = m1.addr;
      sel_wdata_s = m1.wdata;
    end else begin
      sel_cmd_s   = m0.cmd;
      sel_width_s = m0.width;
      sel_addr_s  = m0.addr;
      sel_wdata_s = m0.wdata;
    end
    sel_err_s = misaligned_f(sel_width_s, sel_addr_s[1:0]);
  end

  // Port B cycle generation; misaligned requests are acked without touching memory
  always_comb begin
    mem_renb_o  = 1'b0;
    mem_wenb_o  = 1'b0;
    mem_webb_o  = 4'b0000;
    mem_addrb_o = sel_addr_s[AW-1:2];
    mem_datab_o = datab_f(sel_width_s, sel_wdata_s);
    if (gnt_any_s && !sel_err_s) begin
      if (sel_cmd_s) begin
        mem_wenb_o = 1'b1;
        mem_webb_o = webb_f(sel_width_s, sel_addr_s[1:0]);
      end else begin
        mem_renb_o = 1'b1;
      end
    end else begin
      mem_renb_o = 1'b0;
      mem_wenb_o = 1'b0;
    end
  end

  // Next-state for arbitration history and the one-deep response pipeline
  always_comb begin
    last_grant_d = last_grant_q;
    rsp_vld_d    = gnt_any_s;
    rsp_owner_d  = rsp_owner_q;
    rsp_err_d    = rsp_err_q;
    rsp_cmd_d    = rsp_cmd_q;
    rsp_width_d  = rsp_width_q;
    rsp_off_d    = rsp_off_q;
    m0_resp_d    = RESP_IDLE;
    m1_resp_d    = RESP_IDLE;
    if (gnt_any_s) begin
      last_grant_d = gnt_m1_s ? OWN_M1 : OWN_M0;
      rsp_owner_d  = gnt_m1_s ? OWN_M1 : OWN_M0;
      rsp_err_d    = sel_err_s;
      rsp_cmd_d    = sel_cmd_s;
      rsp_width_d  = sel_width_s;
      rsp_off_d    = sel_addr_s[1:0];
      if (gnt_m1_s) begin
        m1_resp_d = sel_err_s ? RESP_ERR : RESP_OK;
      end else begin
        m0_resp_d = sel_err_s ? RESP_ERR : RESP_OK;
      end
    end else begin
      m0_resp_d = RESP_IDLE;
      m1_resp_d = RESP_IDLE;
    end
  end

  // State registers; reset drops any pending response and favours M0 on first contention
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= OWN_M1;
      rsp_vld_q    <= 1'b0;
      rsp_owner_q  <= OWN_M0;
      rsp_err_q    <= 1'b0;
      rsp_cmd_q    <= 1'b0;
      rsp_width_q  <= 2'b00;
      rsp_off_q    <= 2'b00;
      m0_resp_q    <= RESP_IDLE;
      m1_resp_q    <= RESP_IDLE;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_owner_q  <= rsp_owner_d;
      rsp_err_q    <= rsp_err_d;
      rsp_cmd_q    <= rsp_cmd_d;
      rsp_width_q  <= rsp_width_d;
      rsp_off_q    <= rsp_off_d;
      m0_resp_q    <= m0_resp_d;
      m1_resp_q    <= m1_resp_d;
    end
  end

  assign m0.resp = m0_resp_q;
  assign m1.resp = m1_resp_q;

  // Read data arrives from the macro this cycle, so alignment is applied on the fly
  always_comb begin
    rd_aligned_s = rdata_align_f(rsp_width_q, rsp_off_q, mem_qb_i);
    rd_valid_s   = rsp_vld_q & ~rsp_err_q & ~rsp_cmd_q;
    m0.rdata     = 32'h0000_0000;
    m1.rdata     = 32'h0000_0000;
    if (rd_valid_s) begin
      if (rsp_owner_q == OWN_M1) begin
        m1.rdata = rd_aligned_s;
      end else begin
        m0.rdata = rd_aligned_s;
      end
    end else begin
      m0.rdata = 32'h0000_0000;
      m1.rdata = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_scr1_tcm_portb_arb.sv
// Directed bench for scr1_tcm_portb_arb with a small read-first port B memory model.
module tb_scr1_tcm_portb_arb;

  logic        clk;
  logic        rst;
  logic        mem_renb;
  logic        mem_wenb;
  logic [3:0]  mem_webb;
  logic [13:0] mem_addrb;
  logic [31:0] mem_datab;
  logic [31:0] mem_qb;
  logic [31:0] tb_mem [0:16383];

  int total;
  int bad;

  scr1_tcm_portb_arb_if #(.AW(32'd16)) bus0 ();
  scr1_tcm_portb_arb_if #(.AW(32'd16)) bus1 ();

  scr1_tcm_portb_arb #(
    .SCR1_SIZE  (32'h0001_0000),
    .SCR1_WIDTH (32'd32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m0          (bus0),
    .m1          (bus1),
    .mem_renb_o  (mem_renb),
    .mem_wenb_o  (mem_wenb),
    .mem_webb_o  (mem_webb),
    .mem_addrb_o (mem_addrb),
    .mem_datab_o (mem_datab),
    .mem_qb_i    (mem_qb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_renb) mem_qb <= tb_mem[mem_addrb];
    if (mem_wenb) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_webb[b]) tb_mem[mem_addrb][8*b +: 8] <= mem_datab[8*b +: 8];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic req, input logic cmd, input logic [1:0] width,
                        input logic [15:0] addr, input logic [31:0] wdata);
    bus0.req = req; bus0.cmd = cmd; bus0.width = width; bus0.addr = addr; bus0.wdata = wdata;
  endtask

  task automatic drive1(input logic req, input logic cmd, input logic [1:0] width,
                        input logic [15:0] addr, input logic [31:0] wdata);
    bus1.req = req; bus1.cmd = cmd; bus1.width = width; bus1.addr = addr; bus1.wdata = wdata;
  endtask

  task automatic test_reset();
    drive0(1'b1, 1'b0, 2'b10, 16'h0010, 32'h0);
    drive1(1'b1, 1'b1, 2'b10, 16'h0020, 32'h0);
    tick(); tick();
    total++;
    if ({bus0.resp, bus1.resp, mem_renb, mem_wenb} !== 6'b00_00_0_0) begin
      $display("FAIL reset_state: got %b want %b", {bus0.resp, bus1.resp, mem_renb, mem_wenb}, 6'b0);
      bad++;
    end
    total++;
    if ({bus0.rdata, bus1.rdata} !== 64'h0) begin
      $display("FAIL reset_rdata: got %h want 0", {bus0.rdata, bus1.rdata});
      bad++;
    end
    drive0(1'b0, 1'b0, 2'b00, 16'h0, 32'h0);
    drive1(1'b0, 1'b0, 2'b00, 16'h0, 32'h0);
    rst = 1'b0;
    tick();
    total++;
    if ({bus0.resp, bus1.resp} !== 4'b0000) begin
      $display("FAIL reset_release_resp: got %b want 0000", {bus0.resp, bus1.resp});
      bad++;
    end
  endtask

  task automatic test_write_read();
    drive0(1'b1, 1'b1, 2'b10, 16'h0010, 32'hA1B2_C3D4);
    #1;
    total++;
    if ({bus0.req_ack, bus1.req_ack, mem_renb, mem_wenb, mem_webb, mem_addrb, mem_datab} !==
        {1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, 14'h0004, 32'hA1B2_C3D4}) begin
      $display("FAIL wr_word_issue: got ack=%b%b r=%b w=%b be=%b a=%h d=%h want 10 0 1 1111 0004 a1b2c3d4",
               bus0.req_ack, bus1.req_ack, mem_renb, mem_wenb, mem_webb, mem_addrb, mem_datab);
      bad++;
    end
    tick();
    total++;
    if ({bus0.resp, bus1.resp, bus0.rdata} !== {2'b01, 2'b00, 32'h0}) begin
      $display("FAIL wr_word_resp: got r0=%b r1=%b d=%h want 01 00 0", bus0.resp, bus1.resp, bus0.rdata);
      bad++;
    end
    drive0(1'b1, 1'b0, 2'b00, 16'h0012, 32'h0);
    #1;
    total++;
    if ({bus0.req_ack, mem_renb, mem_wenb, mem_addrb} !== {1'b1, 1'b1, 1'b0, 14'h0004}) begin
      $display("FAIL rd_byte_issue: got ack=%b r=%b w=%b a=%h want 1 1 0 0004",
               bus0.req_ack, mem_renb, mem_wenb, mem_addrb);
      bad++;
    end
    tick();
    total++;
    if ({bus0.resp, bus0.rdata} !== {2'b01, 32'h0000_00B2}) begin
      $display("FAIL rd_byte_data: got resp=%b d=%h want 01 000000b2", bus0.resp, bus0.rdata);
      bad++;
    end
    drive0(1'b1, 1'b0, 2'b01, 16'h0012, 32'h0);
    tick();
    total++;
    if ({bus0.resp, bus0.rdata, bus1.rdata} !== {2'b01, 32'h0000_A1B2, 32'h0}) begin
      $display("FAIL rd_half_data: got resp=%b d0=%h d1=%h want 01 0000a1b2 0", bus0.resp, bus0.rdata, bus1.rdata);
      bad++;
    end
    drive0(1'b0, 1'b0, 2'b00, 16'h0, 32'h0);
  endtask

  task automatic test_byte_write();
    drive1(1'b1, 1'b1, 2'b00, 16'h0013, 32'h0000_0055);
    #1;
    total++;
    if ({bus0.req_ack, bus1.req_ack, mem_renb, mem_wenb, mem_webb, mem_addrb, mem_datab} !==
        {1'b0, 1'b1, 1'b0, 1'b1, 4'b1000, 14'h0004, 32'h5555_5555}) begin
      $display("FAIL wr_byte_issue: got ack=%b%b r=%b w=%b be=%b a=%h d=%h want 01 0 1 1000 0004 55555555",
               bus0.req_ack, bus1.req_ack, mem_renb, mem_wenb, mem_webb, mem_addrb, mem_datab);
      bad++;
    end
    tick();
    total++;
    if ({bus0.resp, bus1.resp} !== 4'b0001) begin
      $display("FAIL wr_byte_resp: got r0=%b r1=%b want 00 01", bus0.resp, bus1.resp);
      bad++;
    end
    drive1(1'b1, 1'b1, 2'b10, 16'h0014, 32'h1234_5678);
    #1;
    total++;
    if ({mem_wenb, mem_webb, mem_addrb} !== {1'b1, 4'b1111, 14'h0005}) begin
      $display("FAIL wr_word2_issue: got w=%b be=%b a=%h want 1 1111 0005", mem_wenb, mem_webb, mem_addrb);
      bad++;
    end
    tick();
    drive1(1'b1, 1'b0, 2'b10, 16'h0010, 32'h0);
    tick();
    total++;
    if ({bus1.resp, bus1.rdata, bus0.rdata} !== {2'b01, 32'h55B2_C3D4, 32'h0}) begin
      $display("FAIL rd_after_byte_wr: got resp=%b d1=%h d0=%h want 01 55b2c3d4 0", bus1.resp, bus1.rdata, bus0.rdata);
      bad++;
    end
    drive1(1'b0, 1'b0, 2'b00, 16'h0, 32'h0);
  endtask

  task automatic test_contention();
    logic [1:0] exp_ack;
    drive0(1'b1, 1'b0, 2'b10, 16'h0010, 32'h0);
    drive1(1'b1, 1'b0, 2'b10, 16'h0014, 32'h0);
    for (int i = 0; i < 4; i++) begin
      exp_ack = ((i % 2) == 0) ? 2'b10 : 2'b01;
      #1;
      total++;
      if ({bus0.req_ack, bus1.req_ack} !== exp_ack) begin
        $display("FAIL contention_ack%0d: got %b want %b", i, {bus0.req_ack, bus1.req_ack}, exp_ack);
        bad++;
      end
      tick();
      total++;
      if (exp_ack == 2'b10) begin
        if ({bus0.resp, bus1.resp, bus0.rdata} !== {2'b01, 2'b00, 32'h55B2_C3D4}) begin
          $display("FAIL contention_resp%0d: got r0=%b r1=%b d0=%h want 01 00 55b2c3d4",
                   i, bus0.resp, bus1.resp, bus0.rdata);
          bad++;
        end
      end else begin
        if ({bus0.resp, bus1.resp, bus1.rdata} !== {2'b00, 2'b01, 32'h1234_5678}) begin
          $display("FAIL contention_resp%0d: got r0=%b r1=%b d1=%h want 00 01 12345678",
                   i, bus0.resp, bus1.resp, bus1.rdata);
          bad++;
        end
      end
    end
    drive0(1'b0, 1'b0, 2'b00, 16'h0, 32'h0);
    drive1(1'b0, 1'b0, 2'b00, 16'h0, 32'h0);
  endtask

  task automatic test_misaligned();
    logic [1:0]  mw [3];
    logic [15:0] ma [3];
    logic        mc [3];
    mw[0] = 2'b10; ma[0] = 16'h0006; mc[0] = 1'b0;
    mw[1] = 2'b01; ma[1] = 16'h0001; mc[1] = 1'b0;
    mw[2] = 2'b11; ma[2] = 16'h0000; mc[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive1(1'b1, mc[i], mw[i], ma[i], 32'hFFFF_FFFF);
      #1;
      total++;
      if ({bus0.req_ack, bus1.req_ack, mem_renb, mem_wenb} !== 4'b0100) begin
        $display("FAIL misalign_issue%0d: got %b want 0100", i,
                 {bus0.req_ack, bus1.req_ack, mem_renb, mem_wenb});
        bad++;
      end
      tick();
      total++;
      if ({bus1.resp, bus0.resp, bus1.rdata} !== {2'b10, 2'b00, 32'h0}) begin
        $display("FAIL misalign_resp%0d: got r1=%b r0=%b d1=%h want 10 00 0", i, bus1.resp, bus0.resp, bus1.rdata);
        bad++;
      end
    end
    drive1(1'b0, 1'b0, 2'b00, 16'h0, 32'h0);
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({bus0.req_ack, bus1.req_ack, mem_renb, mem_wenb, mem_webb} !== 8'h00) begin
        $display("FAIL idle_issue%0d: got %b want 0", i, {bus0.req_ack, bus1.req_ack, mem_renb, mem_wenb, mem_webb});
        bad++;
      end
      tick();
      total++;
      if ({bus0.resp, bus1.resp, bus0.rdata, bus1.rdata} !== 68'h0) begin
        $display("FAIL idle_resp%0d: got r0=%b r1=%b d0=%h d1=%h want 0", i, bus0.resp, bus1.resp, bus0.rdata, bus1.rdata);
        bad++;
      end
    end
  endtask

  task automatic test_reset_mid();
    drive0(1'b1, 1'b1, 2'b10, 16'h0040, 32'hDEAD_BEEF);
    #1;
    total++;
    if ({bus0.req_ack, mem_wenb, mem_addrb} !== {1'b1, 1'b1, 14'h0010}) begin
      $display("FAIL pre_reset_wr: got ack=%b w=%b a=%h want 1 1 0010", bus0.req_ack, mem_wenb, mem_addrb);
      bad++;
    end
    tick();
    drive0(1'b1, 1'b0, 2'b10, 16'h0010, 32'h0);
    rst = 1'b1;
    #1;
    total++;
    if ({bus0.resp, bus1.resp, mem_renb, mem_wenb, bus0.rdata} !== {2'b00, 2'b00, 1'b0, 1'b0, 32'h0}) begin
      $display("FAIL mid_reset_state: got r0=%b r1=%b re=%b we=%b d0=%h want 00 00 0 0 0",
               bus0.resp, bus1.resp, mem_renb, mem_wenb, bus0.rdata);
      bad++;
    end
    tick();
    drive0(1'b1, 1'b0, 2'b10, 16'h0040, 32'h0);
    drive1(1'b1, 1'b0, 2'b10, 16'h0014, 32'h0);
    rst = 1'b0;
    #1;
    total++;
    if ({bus0.resp, bus1.resp, bus0.req_ack, bus1.req_ack} !== 6'b00_00_1_0) begin
      $display("FAIL post_reset_grant: got r0=%b r1=%b ack=%b%b want 00 00 10",
               bus0.resp, bus1.resp, bus0.req_ack, bus1.req_ack);
      bad++;
    end
    tick();
    total++;
    if ({bus0.resp, bus0.rdata} !== {2'b01, 32'hDEAD_BEEF}) begin
      $display("FAIL write_survives_reset: got resp=%b d0=%h want 01 deadbeef", bus0.resp, bus0.rdata);
      bad++;
    end
    total++;
    if ({bus0.req_ack, bus1.req_ack} !== 2'b01) begin
      $display("FAIL post_reset_rr: got %b want 01", {bus0.req_ack, bus1.req_ack});
      bad++;
    end
    drive0(1'b0, 1'b0, 2'b00, 16'h0, 32'h0);
    tick();
    total++;
    if ({bus1.resp, bus0.resp, bus1.rdata} !== {2'b01, 2'b00, 32'h1234_5678}) begin
      $display("FAIL post_reset_m1_rd: got r1=%b r0=%b d1=%h want 01 00 12345678", bus1.resp, bus0.resp, bus1.rdata);
      bad++;
    end
    drive1(1'b0, 1'b0, 2'b00, 16'h0, 32'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive0(1'b0, 1'b0, 2'b00, 16'h0, 32'h0);
    drive1(1'b0, 1'b0, 2'b00, 16'h0, 32'h0);
    test_reset();
    test_write_read();
    test_byte_write();
    test_contention();
    test_misaligned();
    test_idle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
